gf180mcu_fd_sc_mcu9t5v0__nandn_pipe: RTL and testbench

- Parametrised successor to the fixed 4-input NAND cell: CHANNELS independent WIDTH-input NAND/AND reductions, registered through a STAGES-deep pipeline.
- Adds clock-enable stall, valid tracking and a per-sample polarity mode.
- Used as a soft macro where registered wide decode is needed next to the combinational nand2..nand4 cells.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_pkg.sv | 35 +++
 rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_func.sv | 61 ++++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.sv | 50 +++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_pkg.sv
// Shared constants, polarity type and reduction helper for the registered NAND/AND pipeline.
// The legal parameter ranges are checked by the datapath at elaboration.
package gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_pkg;

    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 8;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 16;
    localparam int STAGES_MIN   = 1;
    localparam int STAGES_MAX   = 4;

    // All-ones is the NAND of all-zero inputs, so reset looks like a quiet bus.
    localparam logic [CHANNELS_MAX-1:0] RESET_DATA = '1;

    typedef enum logic {
        POL_NAND = 1'b0,
        POL_AND  = 1'b1
    } polarity_e;

    function automatic logic reduce_bit(
        input logic [WIDTH_MAX-1:0] bits,
        input int                   width,
        input polarity_e            pol
    );
        logic allOnes;
        allOnes = 1'b1;
        for (int k = 0; k < WIDTH_MAX; k++) begin
            if (k < width) begin
                allOnes = allOnes & bits[k];
            end
        end
        return (pol == POL_AND) ? allOnes : ~allOnes;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_func.sv
// Functional core: per-channel NAND/AND reduction feeding a STAGES-deep register pipeline
// with clock-enable stall and a valid bit that travels alongside the data.
module gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_func
    import gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 1,
    parameter int STAGES   = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic                      INV,
    input  logic                      EN,
    input  logic                      VLD_I,
    output logic [CHANNELS-1:0]       ZN,
    output logic                      VLD_O
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_badWidth
        $error("nandn_pipe: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_badChannels
        $error("nandn_pipe: CHANNELS %0d outside %0d..%0d", CHANNELS, CHANNELS_MIN, CHANNELS_MAX);
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_badStages
        $error("nandn_pipe: STAGES %0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
    end

    logic [CHANNELS-1:0] w_result;
    logic [CHANNELS-1:0] r_data [STAGES];
    logic [STAGES-1:0]   r_vld;

    always_comb begin
        w_result = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_result[c] = reduce_bit(WIDTH_MAX'(A[c*WIDTH +: WIDTH]), WIDTH, polarity_e'(INV));
        end
    end

    // Valid never depends on A, so an X sample in a bubble cannot poison VLD_O.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= RESET_DATA[CHANNELS-1:0];
            end
            r_vld <= '0;
        end else if (EN) begin
            r_data[0] <= w_result;
            r_vld[0]  <= VLD_I;
            for (int k = 1; k < STAGES; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
        end
    end

    assign ZN    = r_data[STAGES-1];
    assign VLD_O = r_vld[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.sv
// Cell-level wrapper: supply pins plus timing arcs around the functional pipeline core.
// Defining FUNCTIONAL drops the timing arcs and leaves only the functional model.
module gf180mcu_fd_sc_mcu9t5v0__nandn_pipe
    import gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 1,
    parameter int STAGES   = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic                      INV,
    input  logic                      EN,
    input  logic                      VLD_I,
    output logic [CHANNELS-1:0]       ZN,
    output logic                      VLD_O,
    inout  wire                       VDD,
    inout  wire                       VSS
);

    // Supplies carry no logic; this only gives them a reader.
    wire w_unused_supply;
    assign w_unused_supply = VDD ^ VSS;

    gf180mcu_fd_sc_mcu9t5v0__nandn_pipe_func #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .STAGES   (STAGES)
    ) u_func (
        .CLK   (CLK),
        .RST   (RST),
        .A     (A),
        .INV   (INV),
        .EN    (EN),
        .VLD_I (VLD_I),
        .ZN    (ZN),
        .VLD_O (VLD_O)
    );

`ifndef FUNCTIONAL
    specify
        (CLK *> ZN)    = (1.0, 1.0);
        (CLK => VLD_O) = (1.0, 1.0);
        (RST *> ZN)    = (1.0, 1.0);
        (RST => VLD_O) = (1.0, 1.0);
    endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.sv
// Bench for the registered NAND/AND pipeline: four instances with different shapes share
// clock and control; directed scenarios plus a randomized run against a delay-line model.
module tb_gf180mcu_fd_sc_mcu9t5v0__nandn_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, inv, vldI;
    logic [3:0]  a1;
    logic [7:0]  a2;
    logic [3:0]  a3;
    logic [14:0] a4;
    logic        z1, z3;
    logic [1:0]  z2;
    logic [2:0]  z4;
    logic        v1, v2, v3, v4;
    wire vdd = 1'b1;
    wire vss = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    gf180mcu_fd_sc_mcu9t5v0__nandn_pipe #(.WIDTH(4), .CHANNELS(1), .STAGES(1)) dut1 (
        .CLK(clk), .RST(rst), .A(a1), .INV(inv), .EN(en), .VLD_I(vldI),
        .ZN(z1), .VLD_O(v1), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu9t5v0__nandn_pipe #(.WIDTH(4), .CHANNELS(2), .STAGES(3)) dut2 (
        .CLK(clk), .RST(rst), .A(a2), .INV(inv), .EN(en), .VLD_I(vldI),
        .ZN(z2), .VLD_O(v2), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu9t5v0__nandn_pipe #(.WIDTH(4), .CHANNELS(1), .STAGES(2)) dut3 (
        .CLK(clk), .RST(rst), .A(a3), .INV(inv), .EN(en), .VLD_I(vldI),
        .ZN(z3), .VLD_O(v3), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu9t5v0__nandn_pipe #(.WIDTH(5), .CHANNELS(3), .STAGES(4)) dut4 (
        .CLK(clk), .RST(rst), .A(a4), .INV(inv), .EN(en), .VLD_I(vldI),
        .ZN(z4), .VLD_O(v4), .VDD(vdd), .VSS(vss));

    // Reference: a channel is "all ones" when its slice equals the full mask.
    function automatic logic [15:0] refOut(input logic [127:0] a, input int w, input int ch,
                                           input logic polAnd);
        logic [127:0] mask, chunk;
        logic [15:0]  res;
        res  = '0;
        mask = (128'(1) << w) - 128'(1);
        for (int c = 0; c < ch; c++) begin
            chunk  = (a >> (c * w)) & mask;
            res[c] = polAnd ? (chunk == mask) : (chunk != mask);
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; en = 1'b0; vldI = 1'b0; inv = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; vldI = 1'b1; inv = 1'b0;
        a1 = '1; a2 = '1; a3 = '1; a4 = '1;
        #1;
        vectors++; if (z1 !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_z1: got %b expected 1", z1); end
        vectors++; if (v1 !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_v1: got %b expected 0", v1); end
        vectors++; if (z2 !== 2'b11)  begin miscompares++; $display("[TB] FAIL reset_z2: got %b expected 11", z2); end
        vectors++; if (z4 !== 3'b111) begin miscompares++; $display("[TB] FAIL reset_z4: got %b expected 111", z4); end
        vectors++; if (v4 !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_v4: got %b expected 0", v4); end
        tick();
        vectors++; if (z1 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_wins_z1: got %b expected 1", z1); end
        vectors++; if (v3 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wins_v3: got %b expected 0", v3); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        doReset();
        a1 = 4'hF; inv = 1'b0; vldI = 1'b1; en = 1'b1;
        tick();
        vectors++; if (z1 !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_nand_F: got %b expected 0", z1); end
        vectors++; if (v1 !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_vld: got %b expected 1", v1); end
        a1 = 4'hE;
        tick();
        vectors++; if (z1 !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_nand_E: got %b expected 1", z1); end
    endtask

    task automatic test_stream();
        logic [7:0] samples [3];
        logic [1:0] expZ [3];
        samples = '{8'hFF, 8'h0F, 8'hF0};
        expZ    = '{2'b00, 2'b10, 2'b01};
        doReset();
        en = 1'b1; inv = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            if (e <= 3) begin a2 = samples[e-1]; vldI = 1'b1; end
            else begin a2 = 8'h00; vldI = 1'b0; end
            tick();
            if (e >= 3 && e <= 5) begin
                vectors++; if (z2 !== expZ[e-3]) begin miscompares++; $display("[TB] FAIL stream_z edge %0d: got %b expected %b", e, z2, expZ[e-3]); end
                vectors++; if (v2 !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_v edge %0d: got %b expected 1", e, v2); end
            end else begin
                vectors++; if (v2 !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_v edge %0d: got %b expected 0", e, v2); end
            end
        end
    endtask

    task automatic test_mode();
        doReset();
        en = 1'b1; vldI = 1'b1; a3 = 4'hF; inv = 1'b1;
        tick();
        a3 = 4'hF; inv = 1'b0;
        tick();
        vectors++; if (z3 !== 1'b1) begin miscompares++; $display("[TB] FAIL mode_and: got %b expected 1", z3); end
        vectors++; if (v3 !== 1'b1) begin miscompares++; $display("[TB] FAIL mode_and_v: got %b expected 1", v3); end
        vldI = 1'b0; a3 = 4'h0;
        tick();
        vectors++; if (z3 !== 1'b0) begin miscompares++; $display("[TB] FAIL mode_nand: got %b expected 0", z3); end
        vectors++; if (v3 !== 1'b1) begin miscompares++; $display("[TB] FAIL mode_nand_v: got %b expected 1", v3); end
    endtask

    task automatic test_stall();
        doReset();
        en = 1'b1; a3 = 4'hF; inv = 1'b0; vldI = 1'b1;
        tick();
        en = 1'b0; a3 = 4'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (z3 !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_z cycle %0d: got %b expected 1", i, z3); end
            vectors++; if (v3 !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_v cycle %0d: got %b expected 0", i, v3); end
        end
        en = 1'b1; vldI = 1'b0;
        tick();
        vectors++; if (z3 !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_resume_z: got %b expected 0", z3); end
        vectors++; if (v3 !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_resume_v: got %b expected 1", v3); end
        tick();
        vectors++; if (z3 !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_after_z: got %b expected 1", z3); end
        vectors++; if (v3 !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_after_v: got %b expected 0", v3); end
    endtask

    task automatic test_async_reset();
        doReset();
        en = 1'b1; inv = 1'b0; vldI = 1'b1; a2 = 8'hFF;
        repeat (3) tick();
        vectors++; if (z2 !== 2'b00) begin miscompares++; $display("[TB] FAIL full_z: got %b expected 00", z2); end
        vectors++; if (v2 !== 1'b1)  begin miscompares++; $display("[TB] FAIL full_v: got %b expected 1", v2); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (z2 !== 2'b11) begin miscompares++; $display("[TB] FAIL async_z: got %b expected 11", z2); end
        vectors++; if (v2 !== 1'b0)  begin miscompares++; $display("[TB] FAIL async_v: got %b expected 0", v2); end
        tick();
        vectors++; if (v2 !== 1'b0) begin miscompares++; $display("[TB] FAIL async_hold_v: got %b expected 0", v2); end
        #3 rst = 1'b0;
        vldI = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            vectors++; if (v2 !== 1'b0) begin miscompares++; $display("[TB] FAIL release_v edge %0d: got %b expected 0", e, v2); end
        end
    endtask

    task automatic test_bubbles();
        logic        sV [12];
        logic        sZ [12];
        logic [15:0] r;
        int          idx;
        doReset();
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            vldI = ((i % 2) == 0);
            inv  = 1'($urandom);
            a3   = vldI ? 4'($urandom) : 4'bxxxx;
            r    = refOut(128'(a3), 4, 1, inv);
            sV[i] = vldI;
            sZ[i] = r[0];
            tick();
            idx = i - 1;
            if (idx < 0) begin
                vectors++; if (v3 !== 1'b0) begin miscompares++; $display("[TB] FAIL bubble_v %0d: got %b expected 0", i, v3); end
            end else begin
                vectors++; if (v3 !== sV[idx]) begin miscompares++; $display("[TB] FAIL bubble_v %0d: got %b expected %b", i, v3, sV[idx]); end
                if (sV[idx]) begin
                    vectors++; if (z3 !== sZ[idx]) begin miscompares++; $display("[TB] FAIL bubble_z %0d: got %b expected %b", i, z3, sZ[idx]); end
                end
            end
        end
    endtask

    typedef struct packed {
        logic [2:0] z;
        logic       v;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        ent_t        resetEnt;
        logic [15:0] r;
        resetEnt = '{z: 3'b111, v: 1'b0};
        doReset();
        for (int k = 0; k < 4; k++) q.push_back(resetEnt);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 1'b1;
                #1;
                q.delete();
                for (int k = 0; k < 4; k++) q.push_back(resetEnt);
                vectors++; if ({z4, v4} !== 4'b1110) begin miscompares++; $display("[TB] FAIL rand_reset %0d: got %b/%b expected 111/0", i, z4, v4); end
                rst = 1'b0;
            end
            en   = ($urandom_range(0, 3) != 0);
            vldI = 1'($urandom);
            inv  = 1'($urandom);
            a4   = ($urandom_range(0, 2) == 0) ? 15'h7FFF ^ 15'(1 << $urandom_range(0, 30)) : 15'($urandom);
            r    = refOut(128'(a4), 5, 3, inv);
            tick();
            if (en) begin
                void'(q.pop_front());
                q.push_back('{z: r[2:0], v: vldI});
            end
            vectors++; if (z4 !== q[0].z) begin miscompares++; $display("[TB] FAIL rand_z %0d: got %b expected %b", i, z4, q[0].z); end
            vectors++; if (v4 !== q[0].v) begin miscompares++; $display("[TB] FAIL rand_v %0d: got %b expected %b", i, v4, q[0].v); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_mode();
        test_stall();
        test_async_reset();
        test_bubbles();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
